// File: rtl/btb_update_queue.sv
// BTB update queue: filters committed control instructions down to BTB mispredicts,
// buffers them in a FIFO and issues at most one registered BTB write per cycle.
module btb_update_queue #(
  parameter int unsigned SIZE_PC     = 32,
  parameter int unsigned BRANCH_TYPE = 2,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned DEPTH_LOG   = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ctrlValid0_i,
  input  logic [SIZE_PC-1:0]     ctrlPC0_i,
  input  logic [SIZE_PC-1:0]     ctrlTarget0_i,
  input  logic [BRANCH_TYPE-1:0] ctrlType0_i,
  input  logic                   ctrlBtbHit0_i,
  input  logic [SIZE_PC-1:0]     ctrlPredTarget0_i,
  input  logic [BRANCH_TYPE-1:0] ctrlPredType0_i,
  input  logic                   ctrlValid1_i,
  input  logic [SIZE_PC-1:0]     ctrlPC1_i,
  input  logic [SIZE_PC-1:0]     ctrlTarget1_i,
  input  logic [BRANCH_TYPE-1:0] ctrlType1_i,
  input  logic                   ctrlBtbHit1_i,
  input  logic [SIZE_PC-1:0]     ctrlPredTarget1_i,
  input  logic [BRANCH_TYPE-1:0] ctrlPredType1_i,
  input  logic                   stall_i,
  input  logic                   flush_i,
  output logic                   updateEn_o,
  output logic [SIZE_PC-1:0]     updatePC_o,
  output logic [SIZE_PC-1:0]     updateTargetAddr_o,
  output logic [BRANCH_TYPE-1:0] updateBrType_o,
  output logic                   full_o,
  output logic                   overflow_o
);

  localparam logic [DEPTH_LOG:0] DEPTH_W = (DEPTH_LOG+1)'(DEPTH);
  localparam logic [DEPTH_LOG:0] TWO_W   = (DEPTH_LOG+1)'(2);
  localparam logic [DEPTH_LOG:0] ONE_W   = (DEPTH_LOG+1)'(1);

  logic [SIZE_PC-1:0]     pc_mem   [DEPTH];
  logic [SIZE_PC-1:0]     tgt_mem  [DEPTH];
  logic [BRANCH_TYPE-1:0] type_mem [DEPTH];

  logic [DEPTH_LOG-1:0] head, tail, tail_p1;
  logic [DEPTH_LOG:0]   count, free_slots;
  logic                 qual0, qual1, any_q, both_q;
  logic [1:0]           n_enq;
  logic                 dropped, deq;

  logic [SIZE_PC-1:0]     slot_a_pc, slot_a_tgt;
  logic [BRANCH_TYPE-1:0] slot_a_type;

  assign qual0 = ctrlValid0_i & (~ctrlBtbHit0_i | (ctrlPredTarget0_i != ctrlTarget0_i)
                                 | (ctrlPredType0_i != ctrlType0_i));
  assign qual1 = ctrlValid1_i & (~ctrlBtbHit1_i | (ctrlPredTarget1_i != ctrlTarget1_i)
                                 | (ctrlPredType1_i != ctrlType1_i));
  assign any_q  = qual0 | qual1;
  assign both_q = qual0 & qual1;

  // First slot takes the oldest qualifier; the second slot is only ever lane 1.
  assign slot_a_pc   = qual0 ? ctrlPC0_i     : ctrlPC1_i;
  assign slot_a_tgt  = qual0 ? ctrlTarget0_i : ctrlTarget1_i;
  assign slot_a_type = qual0 ? ctrlType0_i   : ctrlType1_i;

  assign free_slots = DEPTH_W - count;
  assign full_o     = (free_slots < TWO_W);
  assign tail_p1    = tail + DEPTH_LOG'(1);
  assign deq        = (count != '0) & ~stall_i & ~flush_i;

  // Free space is judged on the start-of-cycle count, so a same-cycle dequeue never frees a slot.
  always_comb begin
    n_enq   = 2'd0;
    dropped = 1'b0;
    if (!flush_i) begin
      if (free_slots >= TWO_W) begin
        n_enq = both_q ? 2'd2 : (any_q ? 2'd1 : 2'd0);
      end else if (free_slots == ONE_W) begin
        n_enq   = any_q ? 2'd1 : 2'd0;
        dropped = both_q;
      end else begin
        dropped = any_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + DEPTH_LOG'(deq);
      tail  <= tail + DEPTH_LOG'(n_enq);
      count <= count + (DEPTH_LOG+1)'(n_enq) - (DEPTH_LOG+1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) begin
      pc_mem[tail]   <= slot_a_pc;
      tgt_mem[tail]  <= slot_a_tgt;
      type_mem[tail] <= slot_a_type;
    end
    if (n_enq == 2'd2) begin
      pc_mem[tail_p1]   <= ctrlPC1_i;
      tgt_mem[tail_p1]  <= ctrlTarget1_i;
      type_mem[tail_p1] <= ctrlType1_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      updateEn_o         <= 1'b0;
      updatePC_o         <= '0;
      updateTargetAddr_o <= '0;
      updateBrType_o     <= '0;
      overflow_o         <= 1'b0;
    end else begin
      updateEn_o <= deq;
      overflow_o <= dropped;
      if (deq) begin
        updatePC_o         <= pc_mem[head];
        updateTargetAddr_o <= tgt_mem[head];
        updateBrType_o     <= type_mem[head];
      end
    end
  end

endmodule
